// File: rtl/rtc_bcd_counter.sv
// Real-time clock keeping HH:MM:SS in BCD, advanced by a synchronised 1 Hz input
// and loadable through a four-phase SET_REQ/SET_ACK handshake with BCD validation.
module rtc_bcd_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CK_1HZ,
    input  logic       RUN,
    input  logic       SET_REQ,
    input  logic [7:0] SET_HH,
    input  logic [7:0] SET_MM,
    input  logic [7:0] SET_SS,
    output logic       SET_ACK,
    output logic [7:0] HH,
    output logic [7:0] MM,
    output logic [7:0] SS,
    output logic       SEC_TICK,
    output logic       DAY_TICK,
    output logic       ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACK
    } set_state_e;

    localparam logic [7:0] FIELD_MAX [3] = '{8'h59, 8'h59, 8'h23};

    set_state_e             state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   chain_d;
    logic                   prev_q;
    logic [7:0]             hh_q, mm_q, ss_q;
    logic [7:0]             hh_d, mm_d, ss_d;
    logic                   ack_q, err_q, sec_tick_q, day_tick_q;
    logic                   tick, count_en, ss_wrap, mm_wrap, hh_wrap;
    logic [7:0]             set_field [3];
    logic [2:0]             field_ok;
    logic                   set_valid;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign set_field[0] = SET_SS;
    assign set_field[1] = SET_MM;
    assign set_field[2] = SET_HH;

    // A field is loadable only if both digits are decimal and it is within its range.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field_chk
            assign field_ok[gi] = (set_field[gi][7:4] <= 4'd9) &&
                                  (set_field[gi][3:0] <= 4'd9) &&
                                  (set_field[gi] <= FIELD_MAX[gi]);
        end
    endgenerate

    assign set_valid = &field_ok;

    always_comb begin
        chain_d  = {sync_q, CK_1HZ};
        tick     = sync_q[SYNC_STAGES-1] & ~prev_q;
        count_en = tick & RUN & (state_q != ST_LOAD);
        ss_wrap  = (ss_q == 8'h59);
        mm_wrap  = (mm_q == 8'h59);
        hh_wrap  = (hh_q == 8'h23);
        ss_d     = ss_wrap ? 8'h00 : bcd_inc(ss_q);
        mm_d     = mm_q;
        hh_d     = hh_q;
        if (ss_wrap) begin
            mm_d = mm_wrap ? 8'h00 : bcd_inc(mm_q);
            if (mm_wrap) begin
                hh_d = hh_wrap ? 8'h00 : bcd_inc(hh_q);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // Presetting the detector high means a CK_1HZ already high at release is not a second.
            sync_q     <= '1;
            prev_q     <= 1'b1;
            state_q    <= ST_IDLE;
            hh_q       <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            sync_q     <= chain_d[SYNC_STAGES-1:0];
            prev_q     <= sync_q[SYNC_STAGES-1];
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (SET_REQ) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_ACK;
                    ack_q   <= 1'b1;
                    if (set_valid) begin
                        hh_q  <= SET_HH;
                        mm_q  <= SET_MM;
                        ss_q  <= SET_SS;
                        err_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!SET_REQ) begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // The LOAD cycle swallows any coincident tick, so the two never collide.
            if (count_en) begin
                ss_q       <= ss_d;
                mm_q       <= mm_d;
                hh_q       <= hh_d;
                sec_tick_q <= 1'b1;
                day_tick_q <= ss_wrap & mm_wrap & hh_wrap;
            end
        end
    end

    assign HH       = hh_q;
    assign MM       = mm_q;
    assign SS       = ss_q;
    assign SET_ACK  = ack_q;
    assign ERR      = err_q;
    assign SEC_TICK = sec_tick_q;
    assign DAY_TICK = day_tick_q;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Self-checking bench for rtc_bcd_counter: a seconds-of-day reference model checked
// every cycle, a table of load vectors, directed corner sequences and random traffic.
module tb_rtc_bcd_counter;

    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CK_1HZ = 1'b0;
    logic       RUN = 1'b0;
    logic       SET_REQ = 1'b0;
    logic [7:0] SET_HH = 8'h00;
    logic [7:0] SET_MM = 8'h00;
    logic [7:0] SET_SS = 8'h00;
    logic       SET_ACK;
    logic [7:0] HH, MM, SS;
    logic       SEC_TICK, DAY_TICK, ERR;

    rtc_bcd_counter #(.SYNC_STAGES(S)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CK_1HZ   (CK_1HZ),
        .RUN      (RUN),
        .SET_REQ  (SET_REQ),
        .SET_HH   (SET_HH),
        .SET_MM   (SET_MM),
        .SET_SS   (SET_SS),
        .SET_ACK  (SET_ACK),
        .HH       (HH),
        .MM       (MM),
        .SS       (SS),
        .SEC_TICK (SEC_TICK),
        .DAY_TICK (DAY_TICK),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: time as seconds since midnight ----------------
    int m_sec;
    int m_phase;   // 0 waiting for request, 1 loading, 2 acknowledging
    bit m_sec_tick, m_day_tick, m_ack, m_err, m_tick;
    bit hist [S+2]; // CK_1HZ samples, hist[0] newest

    function automatic int dec(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit fld_ok(input logic [7:0] v, input int lim);
        return (int'(v[7:4]) <= 9) && (int'(v[3:0]) <= 9) && (dec(v) <= lim);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            m_sec = 0; m_phase = 0;
            m_sec_tick = 0; m_day_tick = 0; m_ack = 0; m_err = 0;
            for (int i = 0; i < S + 2; i++) hist[i] = 1'b1;
        end else begin
            for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = CK_1HZ;
            m_tick = hist[S] && !hist[S+1];
            m_sec_tick = 0;
            m_day_tick = 0;
            if (m_phase == 1) begin
                if (fld_ok(SET_HH, 23) && fld_ok(SET_MM, 59) && fld_ok(SET_SS, 59)) begin
                    m_sec = dec(SET_HH) * 3600 + dec(SET_MM) * 60 + dec(SET_SS);
                    m_err = 0;
                end else begin
                    m_err = 1;
                end
            end else if (m_tick && RUN) begin
                m_sec = (m_sec + 1) % 86400;
                m_sec_tick = 1;
                m_day_tick = (m_sec == 0);
            end
            case (m_phase)
                0: if (SET_REQ) m_phase = 1;
                1: m_phase = 2;
                default: if (!SET_REQ) m_phase = 0;
            endcase
            m_ack = (m_phase == 2);
        end
    end

    logic [27:0] dut_vec, mdl_vec;
    assign dut_vec = {HH, MM, SS, SEC_TICK, DAY_TICK, SET_ACK, ERR};
    always_comb mdl_vec = {to_bcd(m_sec / 3600), to_bcd((m_sec / 60) % 60), to_bcd(m_sec % 60),
                           m_sec_tick, m_day_tick, m_ack, m_err};

    bit chk_en = 0;
    int sec_pulses = 0;
    int day_pulses = 0;

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model", {4'h0, dut_vec}, {4'h0, mdl_vec});
            if (SEC_TICK) sec_pulses++;
            if (DAY_TICK) day_pulses++;
        end
    end

    // ---------------- stimulus helpers (always entered and left at a negedge) ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic one_second(output int lat);
        lat = 0;
        CK_1HZ = 1'b1;
        for (int k = 1; k <= S + 3; k++) begin
            cyc(1);
            if (SEC_TICK && lat == 0) lat = k;
        end
        CK_1HZ = 1'b0;
        cyc(S + 2);
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        int cnt;
        SET_HH = h; SET_MM = m; SET_SS = s;
        SET_REQ = 1'b1;
        cnt = 0;
        do begin cyc(1); cnt++; end while (!SET_ACK && cnt < 10);
        check("ack_latency", cnt, 2);
        SET_REQ = 1'b0;
        cnt = 0;
        do begin cyc(1); cnt++; end while (SET_ACK && cnt < 10);
        check("ack_release", cnt, 1);
    endtask

    typedef struct {
        logic [7:0]  hh, mm, ss;
        logic        exp_err;
        logic [23:0] exp_time;
    } load_vec_t;

    load_vec_t tbl [8];

    initial begin
        int lat, p0, d0, cnt, ck_left;
        logic [7:0] s0;

        tbl[0] = '{8'h23, 8'h59, 8'h58, 1'b0, 24'h235958};
        tbl[1] = '{8'h00, 8'h60, 8'h00, 1'b1, 24'h235958};
        tbl[2] = '{8'h12, 8'h34, 8'h56, 1'b0, 24'h123456};
        tbl[3] = '{8'h24, 8'h00, 8'h00, 1'b1, 24'h123456};
        tbl[4] = '{8'h1A, 8'h00, 8'h00, 1'b1, 24'h123456};
        tbl[5] = '{8'h09, 8'h59, 8'h59, 1'b0, 24'h095959};
        tbl[6] = '{8'h00, 8'h00, 8'h5A, 1'b1, 24'h095959};
        tbl[7] = '{8'h20, 8'h00, 8'h00, 1'b0, 24'h200000};

        cyc(1);
        chk_en = 1;
        check("reset_state", {4'h0, dut_vec}, 32'h0);
        cyc(1);
        RESET = 1'b0;
        RUN = 1'b1;
        cyc(2);

        // Three seconds from reset, each with fixed synchroniser latency.
        p0 = sec_pulses;
        for (int i = 0; i < 3; i++) begin
            one_second(lat);
            check("tick_latency", lat, S + 1);
        end
        check("ss_after_3", SS, 8'h03);
        check("sec_pulses_3", sec_pulses - p0, 3);

        // Load table with the counter idle.
        RUN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load(tbl[i].hh, tbl[i].mm, tbl[i].ss);
            $display("load %02h:%02h:%02h -> %02h:%02h:%02h err=%0d", tbl[i].hh, tbl[i].mm,
                     tbl[i].ss, HH, MM, SS, ERR);
            check("tbl_time", {HH, MM, SS}, tbl[i].exp_time);
            check("tbl_err", ERR, tbl[i].exp_err);
        end

        // Rollovers.
        RUN = 1'b1;
        load(8'h23, 8'h59, 8'h58);
        d0 = day_pulses;
        one_second(lat);
        check("to_235959", {HH, MM, SS}, 24'h235959);
        one_second(lat);
        check("day_wrap", {HH, MM, SS}, 24'h000000);
        check("day_pulse", day_pulses - d0, 1);
        load(8'h00, 8'h00, 8'h09);
        one_second(lat);
        check("ss_09_10", {HH, MM, SS}, 24'h000010);
        load(8'h00, 8'h09, 8'h59);
        one_second(lat);
        check("mm_09_10", {HH, MM, SS}, 24'h001000);

        // RUN=0 holds time and drops ticks; resuming adds exactly one.
        s0 = SS;
        p0 = sec_pulses;
        RUN = 1'b0;
        for (int i = 0; i < 5; i++) one_second(lat);
        check("hold_ss", SS, s0);
        check("hold_pulses", sec_pulses - p0, 0);
        RUN = 1'b1;
        one_second(lat);
        check("resume_ss", SS, 8'h01);

        // Load exit on the tick edge, then keep SET_REQ high across another second.
        p0 = sec_pulses;
        CK_1HZ = 1'b1;
        cyc(S - 1);
        SET_HH = 8'h12; SET_MM = 8'h00; SET_SS = 8'h00;
        SET_REQ = 1'b1;
        cyc(S + 2);
        check("coinc_ack", SET_ACK, 1'b1);
        check("coinc_time", {HH, MM, SS}, 24'h120000);
        check("coinc_no_tick", sec_pulses - p0, 0);
        CK_1HZ = 1'b0;
        cyc(S + 1);
        CK_1HZ = 1'b1;
        cyc(S + 2);
        SET_REQ = 1'b0;
        CK_1HZ = 1'b0;
        cyc(S + 2);
        check("single_load", {HH, MM, SS}, 24'h120001);
        check("single_pulse", sec_pulses - p0, 1);

        // Reset in ACK with CK_1HZ high and SET_REQ still asserted.
        SET_HH = 8'h05; SET_MM = 8'h06; SET_SS = 8'h07;
        SET_REQ = 1'b1;
        cyc(2);
        check("rst_pre_ack", SET_ACK, 1'b1);
        CK_1HZ = 1'b1;
        cyc(1);
        RESET = 1'b1;
        cyc(2);
        check("rst_zero", {4'h0, dut_vec}, 32'h0);
        p0 = sec_pulses;
        RESET = 1'b0;
        cnt = 0;
        do begin cyc(1); cnt++; end while (!SET_ACK && cnt < 10);
        check("rst_reload_lat", cnt, 2);
        cyc(S + 3);
        check("rst_reload_time", {HH, MM, SS}, 24'h050607);
        check("rst_no_tick", sec_pulses - p0, 0);
        SET_REQ = 1'b0;
        CK_1HZ = 1'b0;
        cyc(S + 2);

        // Random traffic against the model.
        ck_left = S + 1;
        for (int i = 0; i < 3000; i++) begin
            RESET = ($urandom_range(0, 799) == 0);
            if (ck_left == 0) begin
                CK_1HZ = ~CK_1HZ;
                ck_left = $urandom_range(S + 1, S + 8);
            end
            ck_left--;
            if ($urandom_range(0, 49) == 0) RUN = ~RUN;
            if (!SET_REQ && !SET_ACK && $urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    SET_HH = 8'h23; SET_MM = 8'h59;
                    SET_SS = {4'h5, 4'($urandom_range(0, 9))};
                end else begin
                    SET_HH = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 10))};
                    SET_MM = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
                    SET_SS = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
                end
                SET_REQ = 1'b1;
            end else if (SET_REQ && SET_ACK && $urandom_range(0, 3) == 0) begin
                SET_REQ = 1'b0;
            end
            cyc(1);
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/rtc_bcd_counter.md
RTC_BCD_COUNTER -- requirements
Module: rtc_bcd_counter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of CLK flops on CK_1HZ before edge detect (legal range 1..4).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port CK_1HZ, input, 1 bit: 1 Hz square wave from the clock divider; each rising edge is one second.
REQ-005 SHALL have port RUN, input, 1 bit: 1 = count seconds, 0 = hold time.
REQ-006 SHALL have port SET_REQ, input, 1 bit: time-load request, four-phase handshake.
REQ-007 SHALL have ports SET_HH, SET_MM and SET_SS, each input, 8 bits: BCD load values, stable while SET_REQ=1.
REQ-008 SHALL have port SET_ACK, output, 1 bit: load acknowledge.
REQ-009 SHALL have ports HH, MM and SS, each output, 8 bits: current time in registered BCD.
REQ-010 SHALL have port SEC_TICK, output, 1 bit: one-cycle pulse when SS advances.
REQ-011 SHALL have port DAY_TICK, output, 1 bit: one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.
REQ-012 SHALL have port ERR, output, 1 bit: sticky flag for a rejected (invalid BCD) load.

Function
REQ-013 SHALL pass CK_1HZ through a SYNC_STAGES-deep flop chain and then a prev flop; tick = chain_last & ~prev.
REQ-014 SHALL apply a tick on the CLK edge where tick=1, so SS changes at the (SYNC_STAGES+1)-th edge after the first edge that samples CK_1HZ=1.
REQ-015 SHALL produce exactly one tick per CK_1HZ rising edge, with CK_1HZ high/low periods of at least SYNC_STAGES+1 CLK cycles.
REQ-016 SHALL discard a tick when RUN=0 (no queuing); the edge detector keeps tracking CK_1HZ regardless of RUN.
REQ-017 SHALL count SS 00..59 in BCD; SS=59 wraps to 00 and increments MM.
REQ-018 SHALL count MM 00..59 in BCD; MM wrap increments HH.
REQ-019 SHALL count HH 00..23; 23 wraps to 00.
REQ-020 SHALL roll BCD digits correctly (e.g. 09 -> 10, 19 -> 20); no binary values 0x0A..0x0F ever appear on HH, MM or SS.
REQ-021 SHALL register SEC_TICK high for exactly the first cycle in which the new SS is visible.
REQ-022 SHALL register DAY_TICK high in that same cycle only when HH:MM:SS becomes 00:00:00 by counting.
REQ-023 SHALL implement the set FSM as IDLE -> LOAD (SET_REQ=1 sampled in IDLE) -> ACK (after one cycle); ACK -> IDLE when SET_REQ=0 is sampled.
REQ-024 In LOAD, SHALL validate: every nibble <= 9, SS <= 0x59, MM <= 0x59, HH <= 0x23.
REQ-025 If valid, SHALL write HH/MM/SS at the LOAD exit edge and clear ERR.
REQ-026 If invalid, SHALL leave the time unchanged and set ERR=1.
REQ-027 SHALL hold SET_ACK=1 throughout ACK and 0 otherwise, so it rises 2 edges after SET_REQ is first sampled high.
REQ-028 SHALL give a load priority over a tick applied on the same edge: the tick is discarded, with no SEC_TICK or DAY_TICK.
REQ-029 SHALL ignore SET_REQ held high in ACK; one handshake gives one load.
REQ-030 SHALL keep a load from ever producing SEC_TICK or DAY_TICK.

Reset
REQ-031 On a RESET=1 edge, SHALL set HH=MM=SS=0x00, SEC_TICK=DAY_TICK=SET_ACK=ERR=0 and FSM=IDLE.
REQ-032 On a RESET=1 edge, SHALL preset the sync chain and prev to 1, so a CK_1HZ already high at release gives no tick; the first second counts only after a sampled 0 -> 1.
REQ-033 RESET SHALL override any in-progress handshake or tick; if SET_REQ is still 1 after release, a new LOAD starts from IDLE.

Verification
REQ-034 Reset, RUN=1, 3 CK_1HZ edges -> SS=0x03, 3 SEC_TICK pulses, each SEC_TICK exactly SYNC_STAGES+1 edges after the CK_1HZ rise.
REQ-035 Load 23:59:58 then 2 ticks -> 23:59:59, then 00:00:00 with DAY_TICK=1 for one cycle; also 00:00:09 -> 00:00:10 and 00:09:59 -> 00:10:00.
REQ-036 Load SET_MM=0x60 -> ERR=1, time unchanged, SET_ACK handshake completes; then valid load 12:34:56 -> ERR=0, time=12:34:56.
REQ-037 RUN=0 across 5 CK_1HZ edges -> SS unchanged, no SEC_TICK; RUN=1 -> next edge increments by exactly 1.
REQ-038 SET_REQ timed so LOAD exit coincides with a tick -> time = loaded value, no SEC_TICK; SET_REQ held 10 cycles -> single load.
REQ-039 RESET asserted in ACK and while CK_1HZ=1 -> outputs zeroed, no spurious tick after release; SET_REQ still high -> reload completes.
